dtc_stub_readout: RTL and testbench

//  Downstream of the CIC stub extractor. Drains the 8 per-chip MPA stub BRAMs
//  (21-bit stubs, 7-bit address) after each frame window.

---
 rtl/dtc_pkg.sv | 34 +++
 rtl/dtc_stream_if.sv | 13 +
 rtl/dtc_skid_buf.sv | 59 +++++
 rtl/dtc_stub_readout.sv | 141 ++++++++++++++
 tb/tb_dtc_stub_readout.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtc_pkg.sv
// Shared constants, FSM encoding and the bank priority encoder for the
// stub readout path.
package dtc_pkg;

   localparam int N_BANKS  = 8;
   localparam int STUB_W   = 21;
   localparam int ADDR_W   = 7;
   localparam int DEPTH    = 128;
   localparam int CNT_W    = 8;
   localparam int CHIPID_W = 3;
   localparam int BANK_W   = $clog2(N_BANKS);
   localparam int WORD_W   = CHIPID_W + STUB_W;

   typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, FIN} state_t;

   typedef struct packed {
      logic              found;
      logic [BANK_W-1:0] idx;
   } pick_t;

   // Lowest bank index strictly above 'cur' whose mask bit is set.
   function automatic pick_t next_bank(input logic [N_BANKS-1:0] mask, input int cur);
      pick_t p;
      p = '0;
      for (int i = N_BANKS - 1; i >= 0; i--) begin
         if (mask[i] && i > cur) begin
            p.found = 1'b1;
            p.idx   = BANK_W'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/dtc_stream_if.sv
// Valid/ready stream carrying {last, chipID, stub} words out of the readout.
interface dtc_stream_if;
   import dtc_pkg::*;

   logic              valid;
   logic              ready;
   logic              last;
   logic [WORD_W-1:0] data;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/dtc_skid_buf.sv
// Two-entry skid buffer with same-cycle bypass when empty; almost_full counts
// the word arriving this cycle so the issuer never overruns the two slots.
module dtc_skid_buf #(
   parameter int W = dtc_pkg::WORD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         almost_full
);

   logic [1:0]   count;
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic         acc;

   assign out_valid   = (count != 2'd0) || in_valid;
   assign out_data    = (count != 2'd0) ? head : in_data;
   assign acc         = out_valid && out_ready;
   assign almost_full = count[1] || (count[0] && in_valid);

   // NOTE: sequential state uses non-blocking assignments; head/tail are
   // deliberately not reset because count alone says whether they hold data.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
      end else begin
         case (count)
            2'd0: begin
               if (in_valid && !acc) begin
                  head  <= in_data;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               if (acc && in_valid) begin
                  head <= in_data;
               end else if (acc) begin
                  count <= 2'd0;
               end else if (in_valid) begin
                  tail  <= in_data;
                  count <= 2'd2;
               end
            end
            default: begin
               if (acc) begin
                  head  <= tail;
                  count <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/dtc_stub_readout.sv
// Drains the per-chip stub banks in ascending chip order into one stream,
// hiding the 1-cycle bank read latency behind a 2-entry skid buffer.
module dtc_stub_readout
   import dtc_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [N_BANKS*CNT_W-1:0]  bank_cnt,
   output logic [N_BANKS-1:0]        rd_en,
   output logic [ADDR_W-1:0]         rd_addr,
   input  logic [N_BANKS*STUB_W-1:0] rd_data,
   dtc_stream_if.master              stream,
   output logic                      busy,
   output logic                      done,
   output logic                      cnt_ovf
);

   state_t              state;
   logic [CNT_W-1:0]    cnt_q     [N_BANKS];
   logic [CNT_W-1:0]    clamp     [N_BANKS];
   logic [STUB_W-1:0]   bank_word [N_BANKS];
   logic [N_BANKS-1:0]  clamp_ovf;
   logic [N_BANKS-1:0]  clamp_nz;
   logic [N_BANKS-1:0]  nz;
   logic [BANK_W-1:0]   cur;
   logic [ADDR_W:0]     addr;
   logic                fl_valid;
   logic                fl_last;
   logic [BANK_W-1:0]   fl_bank;
   logic [WORD_W:0]     sk_in;
   logic [WORD_W:0]     sk_out;
   logic                almost_full;
   logic                issue;
   logic                bank_end;
   pick_t               first_pick;
   pick_t               next_pick;

   // NOTE: every always_comb output is assigned on every path, so no latches.
   always_comb begin
      clamp_ovf = '0;
      for (int k = 0; k < N_BANKS; k++) begin
         clamp[k] = bank_cnt[k*CNT_W +: CNT_W];
         if (clamp[k] > CNT_W'(DEPTH)) begin
            clamp[k]     = CNT_W'(DEPTH);
            clamp_ovf[k] = 1'b1;
         end
         clamp_nz[k]  = (clamp[k] != '0);
         nz[k]        = (cnt_q[k] != '0);
         bank_word[k] = rd_data[k*STUB_W +: STUB_W];
      end
   end

   assign first_pick = next_bank(clamp_nz, -1);
   assign next_pick  = next_bank(nz, int'(cur));
   assign issue      = (state == READ) && !almost_full;
   assign bank_end   = (addr + 1'b1) == (ADDR_W+1)'(cnt_q[cur]);
   assign rd_en      = issue ? (N_BANKS'(1) << cur) : '0;
   assign rd_addr    = issue ? addr[ADDR_W-1:0] : '0;

   // Only the bank read last cycle is looked at; idle cycles feed zeros.
   assign sk_in = fl_valid ? {fl_last, CHIPID_W'(fl_bank), bank_word[fl_bank]} : '0;

   dtc_skid_buf #(.W(WORD_W + 1)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (fl_valid),
      .in_data     (sk_in),
      .out_valid   (stream.valid),
      .out_ready   (stream.ready),
      .out_data    (sk_out),
      .almost_full (almost_full)
   );

   assign stream.data = sk_out[WORD_W-1:0];
   assign stream.last = sk_out[WORD_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur      <= '0;
         addr     <= '0;
         fl_valid <= 1'b0;
         fl_last  <= 1'b0;
         fl_bank  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt_ovf  <= 1'b0;
         for (int k = 0; k < N_BANKS; k++) cnt_q[k] <= '0;
      end else begin
         fl_valid <= issue;
         fl_bank  <= cur;
         fl_last  <= issue && bank_end && !next_pick.found;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               for (int k = 0; k < N_BANKS; k++) cnt_q[k] <= clamp[k];
               cnt_ovf <= |clamp_ovf;
               cur     <= first_pick.idx;
               addr    <= '0;
               if (first_pick.found) begin
                  state <= READ;
               end else begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            READ: begin
               if (issue) begin
                  if (bank_end) begin
                     addr <= '0;
                     if (next_pick.found) cur <= next_pick.idx;
                     else state <= DRAIN;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (stream.valid && stream.ready && stream.last) begin
                  state <= FIN;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtc_stub_readout.sv
// Directed bench for dtc_stub_readout: bank memories modelled behaviourally,
// expected stream built from clamped counts and checked every cycle.
module tb_dtc_stub_readout;
   import dtc_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      start;
   logic [N_BANKS*CNT_W-1:0]  bank_cnt;
   logic [N_BANKS-1:0]        rd_en;
   logic [ADDR_W-1:0]         rd_addr;
   logic [N_BANKS*STUB_W-1:0] rd_data;
   logic                      busy;
   logic                      done;
   logic                      cnt_ovf;

   dtc_stream_if stream();

   always #5 clk = ~clk;

   dtc_stub_readout dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bank_cnt (bank_cnt),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .stream   (stream),
      .busy     (busy),
      .done     (done),
      .cnt_ovf  (cnt_ovf)
   );

   function automatic logic [STUB_W-1:0] stub_of(input int k, input int a);
      return {5'(k + 1), 8'(a), 8'h5A};
   endfunction

   function automatic logic [N_BANKS*CNT_W-1:0] cnts8(input int c0, c1, c2, c3, c4, c5, c6, c7);
      return {CNT_W'(c7), CNT_W'(c6), CNT_W'(c5), CNT_W'(c4),
              CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
   endfunction

   // Bank memories: douta updates only on its own read enable.
   logic [STUB_W-1:0] douta [N_BANKS];
   always @(posedge clk)
      for (int k = 0; k < N_BANKS; k++)
         if (rd_en[k]) douta[k] <= stub_of(k, int'(rd_addr));
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < N_BANKS; k++) rd_data[k*STUB_W +: STUB_W] = douta[k];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WORD_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cnt_model [N_BANKS];
   int   acc_cnt = 0;
   int   start_cyc = -100;
   bit   empty_mode = 1'b0;
   bit   chk_en = 1'b0;
   bit   hold_pending = 1'b0;
   bit   last_acc_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Per-cycle compare against the expected stream.
   always @(negedge clk) begin
      logic done_exp;
      if (chk_en && !rst) begin
         if (hold_pending) check("valid_hold", 32'(stream.valid), 1);
         if (stream.valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 32'(stream.valid), 0);
            end else begin
               check("out_data", 32'(stream.data), 32'(exp_q[0].data));
               check("out_last", 32'(stream.last), 32'(exp_q[0].last));
               if (stream.ready) begin
                  void'(exp_q.pop_front());
                  acc_cnt++;
               end
            end
         end
         done_exp = last_acc_prev || (empty_mode && cyc == start_cyc + 2);
         check("done", 32'(done), 32'(done_exp));
         if (last_acc_prev) check("busy_after_last", 32'(busy), 0);
         if (rd_en != '0) begin
            check("rd_en_onehot", 32'($onehot(rd_en)), 1);
            for (int k = 0; k < N_BANKS; k++)
               if (rd_en[k]) check("rd_addr_range", 32'(int'(rd_addr) < cnt_model[k]), 1);
         end
         hold_pending  = stream.valid && !stream.ready;
         last_acc_prev = stream.valid && stream.ready && stream.last;
      end else begin
         hold_pending  = 1'b0;
         last_acc_prev = 1'b0;
      end
   end

   // Called just after a rising edge; the start pulse occupies cycle T.
   task automatic start_drain(input logic [N_BANKS*CNT_W-1:0] cnts);
      int cl [N_BANKS];
      int lastk;
      exp_t e;
      lastk = -1;
      for (int k = 0; k < N_BANKS; k++) begin
         cl[k] = int'(cnts[k*CNT_W +: CNT_W]);
         if (cl[k] > DEPTH) cl[k] = DEPTH;
         cnt_model[k] = cl[k];
         if (cl[k] > 0) lastk = k;
      end
      for (int k = 0; k < N_BANKS; k++)
         for (int a = 0; a < cl[k]; a++) begin
            e.data = {CHIPID_W'(k), stub_of(k, a)};
            e.last = (k == lastk) && (a == cl[k] - 1);
            exp_q.push_back(e);
         end
      empty_mode = (lastk < 0);
      start_cyc  = cyc;
      bank_cnt   = cnts;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_until_done(input string name, input int max_cyc, input bit toggle);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            if (toggle) stream.ready = !stream.ready;
         end
      end
      @(posedge clk); #1;
      stream.ready = 1'b1;
      check({name, "_done_seen"}, 32'(seen), 1);
      check({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic check_idle(input string name);
      check({name, "_rd_en"}, 32'(rd_en), 0);
      check({name, "_rd_addr"}, 32'(rd_addr), 0);
      check({name, "_valid"}, 32'(stream.valid), 0);
      check({name, "_data"}, 32'(stream.data), 0);
      check({name, "_last"}, 32'(stream.last), 0);
      check({name, "_busy"}, 32'(busy), 0);
      check({name, "_done"}, 32'(done), 0);
      check({name, "_ovf"}, 32'(cnt_ovf), 0);
   endtask

   task automatic gap();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      bank_cnt     = '0;
      stream.ready = 1'b1;
      for (int k = 0; k < N_BANKS; k++) cnt_model[k] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");
      chk_en = 1'b1;
      gap();

      // Test 1: sparse banks at full rate.
      acc_cnt = 0;
      start_drain(cnts8(3, 0, 0, 2, 0, 0, 0, 1));
      @(negedge clk);                                   // T+1
      check("t1_busy_load", 32'(busy), 1);
      @(negedge clk);                                   // T+2
      check("t1_first_rd_en", 32'(rd_en), 32'h01);
      check("t1_first_rd_addr", 32'(rd_addr), 0);
      check("t1_no_valid_yet", 32'(stream.valid), 0);
      @(negedge clk);                                   // T+3
      check("t1_first_valid", 32'(stream.valid), 1);
      check("t1_first_word", 32'(stream.data), 32'h01005A);
      for (int i = 4; i <= 8; i++) begin
         @(negedge clk);
         check("t1_stream_valid", 32'(stream.valid), 1);
      end
      check("t1_last_flag", 32'(stream.last), 1);       // T+8
      check("t1_last_word", 32'(stream.data), 32'hE8005A);
      @(negedge clk);                                   // T+9
      check("t1_done", 32'(done), 1);
      check("t1_busy_fall", 32'(busy), 0);
      check("t1_word_count", acc_cnt, 6);
      gap();

      // Test 2: all counts zero.
      start_drain('0);
      @(negedge clk);                                   // T+1
      check("t2_busy_t1", 32'(busy), 1);
      check("t2_done_t1", 32'(done), 0);
      @(negedge clk);                                   // T+2
      check("t2_done_t2", 32'(done), 1);
      check("t2_busy_t2", 32'(busy), 1);
      check("t2_ovf", 32'(cnt_ovf), 0);
      check("t2_no_valid", 32'(stream.valid), 0);
      @(negedge clk);                                   // T+3
      check("t2_done_t3", 32'(done), 0);
      check("t2_busy_t3", 32'(busy), 0);
      gap();

      // Test 3: full bank with ready toggling each cycle.
      acc_cnt = 0;
      start_drain(cnts8(128, 0, 0, 0, 0, 0, 0, 0));
      run_until_done("t3", 600, 1'b1);
      check("t3_word_count", acc_cnt, 128);
      gap();

      // Test 4: oversized count clamps and flags; next start clears the flag.
      acc_cnt = 0;
      start_drain(cnts8(200, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);                                   // T+2
      check("t4_ovf_set", 32'(cnt_ovf), 1);
      run_until_done("t4", 400, 1'b0);
      check("t4_word_count", acc_cnt, 128);
      check("t4_ovf_sticky", 32'(cnt_ovf), 1);
      gap();
      acc_cnt = 0;
      start_drain(cnts8(2, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      @(negedge clk);                                   // T+2
      check("t4_ovf_cleared", 32'(cnt_ovf), 0);
      run_until_done("t4b", 50, 1'b0);
      check("t4b_word_count", acc_cnt, 3);
      gap();

      // Test 5: restart attempt and a 10-cycle stall mid-drain.
      acc_cnt = 0;
      start_drain(cnts8(4, 0, 3, 0, 0, 0, 0, 2));
      repeat (2) @(posedge clk);
      #1;                                               // T+3
      start        = 1'b1;
      bank_cnt     = cnts8(5, 5, 5, 5, 5, 5, 5, 5);
      stream.ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("t5_busy_in_stall", 32'(busy), 1);
      check("t5_valid_in_stall", 32'(stream.valid), 1);
      stream.ready = 1'b1;
      run_until_done("t5", 100, 1'b0);
      check("t5_word_count", acc_cnt, 9);
      gap();

      // Test 6: reset mid-drain, then a fresh short drain.
      start_drain(cnts8(5, 5, 5, 0, 0, 0, 0, 0));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle("t6_post_rst");
      @(posedge clk); #1;
      acc_cnt = 0;
      start_drain(cnts8(1, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);                                   // T+3
      check("t6_word0", 32'(stream.data), 32'h01005A);
      check("t6_word0_last", 32'(stream.last), 0);
      @(negedge clk);                                   // T+4
      check("t6_word1", 32'(stream.data), 32'h22005A);
      check("t6_word1_last", 32'(stream.last), 1);
      @(negedge clk);                                   // T+5
      check("t6_done", 32'(done), 1);
      check("t6_word_count", acc_cnt, 2);
      gap();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
